// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERR
   } state_t;

   typedef struct packed {
      logic in_ready;
      logic busy;
      logic done;
      logic err;
      logic core_reset;
   } status_t;

   // Status outputs are a pure function of the state being entered, so the
   // FSM registers them alongside the state and no output decode is needed.
   function automatic status_t statusOf(input state_t s);
      status_t st;
      st = '{in_ready: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0, core_reset: 1'b1};
      case (s)
         LEN_LO, LEN_HI, DATA: begin
            st.in_ready = 1'b1;
            st.busy     = 1'b1;
         end
         DONE: begin
            st.done       = 1'b1;
            st.core_reset = 1'b0;
         end
         ERR: begin
            st.err = 1'b1;
         end
         default: begin
            st.core_reset = 1'b1;
         end
      endcase
      return st;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction memory write port and status bundle.
// The master side drives the stream; the slave side is the loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  core_reset;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, err
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, core_reset, busy, done, err
   );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Collects accepted stream bytes into a little-endian 32-bit word.
// The word-valid pulse is combinational with the lane-3 accept so the
// caller can register the full word on that same edge.
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_clear,
   input  logic                    i_accept,
   input  logic [7:0]              i_data,
   output logic                    o_word_valid,
   output logic [8*WORD_BYTES-1:0] o_word
);

   localparam int                LANE_W    = $clog2(WORD_BYTES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

   logic [LANE_W-1:0]       r_lane;
   logic [8*WORD_BYTES-1:0] r_shift;

   // Lane k byte lands in bits [8k+7:8k]; clear discards any partial word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lane  <= '0;
         r_shift <= '0;
      end else if (i_clear) begin
         r_lane  <= '0;
         r_shift <= '0;
      end else if (i_accept) begin
         r_shift[8*r_lane +: 8] <= i_data;
         r_lane                 <= r_lane + 1'b1;
      end
   end

   // The top byte comes straight from the input, completing the word early.
   always_comb begin
      o_word                                = r_shift;
      o_word[8*(WORD_BYTES-1) +: 8]         = i_data;
      o_word_valid                          = i_accept && (r_lane == LAST_LANE);
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: reads a 16-bit word count and then
// that many little-endian words, writes them to consecutive addresses from
// 0, and holds the core in reset until the whole program is in memory.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   localparam int LEN_W = 8 * LEN_BYTES;
   localparam int CMP_W = (ADDR_WIDTH + 2 > LEN_W + 1) ? ADDR_WIDTH + 2 : LEN_W + 1;
   localparam logic [CMP_W-1:0] CAPACITY = CMP_W'(1) << ADDR_WIDTH;

   state_t                r_state;
   status_t               r_status;
   logic [LEN_W-1:0]      r_len;
   logic [ADDR_WIDTH:0]   r_wcnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;

   logic                  w_accept;
   logic                  w_start;
   logic                  w_len_hi_accept;
   logic                  w_data_accept;
   logic                  w_clear;
   logic [LEN_W-1:0]      w_len;
   logic                  w_last_written;
   logic                  w_word_valid;
   logic [31:0]           w_word;

   assign w_accept        = bus.in_valid && r_status.in_ready;
   assign w_start         = bus.start && !r_status.busy;
   assign w_len_hi_accept = w_accept && (r_state == LEN_HI);
   assign w_data_accept   = w_accept && (r_state == DATA);
   assign w_clear         = w_start || w_len_hi_accept;
   assign w_len           = {bus.in_data, r_len[7:0]};
   assign w_last_written  = r_we && (CMP_W'(r_wcnt) == CMP_W'(r_len));

   byte_word_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_clear),
      .i_accept     (w_data_accept),
      .i_data       (bus.in_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // Session FSM; status flags are loaded together with each new state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_status <= statusOf(IDLE);
         r_len    <= '0;
      end else begin
         case (r_state)
            IDLE, DONE, ERR: begin
               if (w_start) begin
                  r_state  <= LEN_LO;
                  r_status <= statusOf(LEN_LO);
               end
            end
            LEN_LO: begin
               if (w_accept) begin
                  r_len    <= LEN_W'(bus.in_data);
                  r_state  <= LEN_HI;
                  r_status <= statusOf(LEN_HI);
               end
            end
            LEN_HI: begin
               if (w_accept) begin
                  r_len <= w_len;
                  if (w_len == '0) begin
                     r_state  <= DONE;
                     r_status <= statusOf(DONE);
                  end else if (CMP_W'(w_len) > CAPACITY) begin
                     r_state  <= ERR;
                     r_status <= statusOf(ERR);
                  end else begin
                     r_state  <= DATA;
                     r_status <= statusOf(DATA);
                  end
               end
            end
            DATA: begin
               if (w_last_written) begin
                  r_state  <= DONE;
                  r_status <= statusOf(DONE);
               end
            end
            default: begin
               r_state  <= IDLE;
               r_status <= statusOf(IDLE);
            end
         endcase
      end
   end

   // Write port: one-cycle strobe per completed word, address = word index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wcnt  <= '0;
      end else begin
         r_we <= w_word_valid;
         if (w_start) begin
            r_wcnt <= '0;
         end else if (w_word_valid) begin
            r_wcnt  <= r_wcnt + 1'b1;
            r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
            r_wdata <= w_word;
         end
      end
   end

   assign bus.in_ready   = r_status.in_ready;
   assign bus.busy       = r_status.busy;
   assign bus.done       = r_status.done;
   assign bus.err        = r_status.err;
   assign bus.core_reset = r_status.core_reset;
   assign bus.mem_we     = r_we;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: program loads at full and half rate,
// length-header corner cases, restart, and reset in the middle of a word.
module tb_imem_loader;

   localparam int AW = 8;

   typedef struct packed {
      logic [31:0] bytesLE;
      logic [31:0] expWord;
   } word_vec_t;

   typedef struct packed {
      logic [7:0] lo;
      logic [7:0] hi;
      logic       expDone;
      logic       expErr;
      logic       expCoreReset;
      logic       expInReady;
      logic       expBusy;
   } hdr_vec_t;

   logic clk = 1'b0;
   logic reset;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   word_vec_t prog [8];
   hdr_vec_t  hdr  [5];

   logic [AW-1:0] wrAddr [$];
   logic [31:0]   wrData [$];
   int            wrTime [$];

   // Scoreboard of every memory write, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wrAddr.push_back(bus.mem_addr);
         wrData.push_back(bus.mem_wdata);
         wrTime.push_back(int'($time));
      end
   end

   // Hard stop in case something upstream stalls forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clearWrites();
      wrAddr.delete();
      wrData.delete();
      wrTime.delete();
   endtask

   task automatic doReset();
      @(negedge clk);
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseStart();
      bus.start    = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns on the negedge after it was accepted.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         bus.in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept timeout: in_ready %b required 1", bus.in_ready);
         bus.in_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic verifyWrites(input string tag, input int perWord);
      logic [31:0] expAddr;
      checkOutput($sformatf("%s write count", tag), wrAddr.size(), 8);
      for (int i = 0; i < 8; i++) begin
         expAddr = i;
         if (i < wrAddr.size()) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), 32'(wrAddr[i]), expAddr);
            checkOutput($sformatf("%s data[%0d]", tag, i), wrData[i], prog[i].expWord);
         end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s missing write %0d: got none required addr %0d", tag, i, i);
         end
      end
      if (perWord > 0 && wrTime.size() >= 8) begin
         checkOutput($sformatf("%s write spacing", tag), wrTime[7] - wrTime[0], 7 * perWord);
      end
   endtask

   task automatic loadProgram(input int gap, input bit midStart, input string tag);
      logic [31:0] v;
      clearWrites();
      pulseStart();
      checkOutput({tag, " start->in_ready"}, bus.in_ready, 1);
      applyStimulus(8'h08, gap);
      applyStimulus(8'h00, gap);
      for (int w = 0; w < 8; w++) begin
         v = prog[w].bytesLE;
         for (int k = 0; k < 4; k++) begin
            applyStimulus(v[31-8*k -: 8], gap);
            if (midStart && w == 3 && k == 1) begin
               pulseStart();
               checkOutput({tag, " start in DATA busy"}, bus.busy, 1);
            end
         end
      end
      bus.in_valid = 1'b0;
      checkOutput({tag, " last write we"}, bus.mem_we, 1);
      checkOutput({tag, " last write in_ready"}, bus.in_ready, 1);
      checkOutput({tag, " last write core_reset"}, bus.core_reset, 1);
      @(negedge clk);
      checkOutput({tag, " release core_reset"}, bus.core_reset, 0);
      checkOutput({tag, " release done"}, bus.done, 1);
      checkOutput({tag, " release in_ready"}, bus.in_ready, 0);
      verifyWrites(tag, gap == 0 && !midStart ? 40 : (gap == 1 ? 80 : 0));
   endtask

   initial begin
      prog[0] = '{32'h9300803e, 32'h3e800093};
      prog[1] = '{32'h13013000, 32'h00300113};
      prog[2] = '{32'hb3010000, 32'h000001b3};
      prog[3] = '{32'hb3811100, 32'h001181b3};
      prog[4] = '{32'h1301f1ff, 32'hfff10113};
      prog[5] = '{32'he31c01fe, 32'hfe011ce3};
      prog[6] = '{32'h23203000, 32'h00302023};
      prog[7] = '{32'h6ff35fff, 32'hff5ff36f};

      hdr[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      hdr[1] = '{8'h2c, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      hdr[2] = '{8'h01, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      hdr[3] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      hdr[4] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #1;
      checkOutput("reset status {rdy,we,crst,busy,done,err}",
                  {26'd0, bus.in_ready, bus.mem_we, bus.core_reset, bus.busy, bus.done, bus.err},
                  32'b001000);
      checkOutput("reset mem_addr", 32'(bus.mem_addr), 0);
      checkOutput("reset mem_wdata", bus.mem_wdata, 0);
      doReset();

      // Header-only sessions: N=0, over capacity, exactly capacity, one word.
      for (int i = 0; i < 5; i++) begin
         doReset();
         clearWrites();
         pulseStart();
         applyStimulus(hdr[i].lo, 0);
         applyStimulus(hdr[i].hi, 0);
         bus.in_valid = 1'b0;
         checkOutput($sformatf("hdr%0d done", i), bus.done, hdr[i].expDone);
         checkOutput($sformatf("hdr%0d err", i), bus.err, hdr[i].expErr);
         checkOutput($sformatf("hdr%0d core_reset", i), bus.core_reset, hdr[i].expCoreReset);
         checkOutput($sformatf("hdr%0d in_ready", i), bus.in_ready, hdr[i].expInReady);
         checkOutput($sformatf("hdr%0d busy", i), bus.busy, hdr[i].expBusy);
         repeat (2) @(negedge clk);
         checkOutput($sformatf("hdr%0d no writes", i), wrAddr.size(), 0);
      end

      // Full-rate load.
      doReset();
      loadProgram(0, 1'b0, "full");

      // Over-capacity error, bytes ignored while in ERR, then recovery.
      doReset();
      clearWrites();
      pulseStart();
      applyStimulus(8'h2c, 0);
      applyStimulus(8'h01, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h93;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("err holds", bus.err, 1);
      checkOutput("err core_reset", bus.core_reset, 1);
      checkOutput("err no writes", wrAddr.size(), 0);
      loadProgram(0, 1'b0, "afterErr");

      // Restart from DONE reasserts core reset on the next cycle.
      pulseStart();
      checkOutput("restart core_reset", bus.core_reset, 1);
      checkOutput("restart done", bus.done, 0);
      checkOutput("restart busy", bus.busy, 1);

      // Asynchronous reset after word 2 plus half of word 3.
      doReset();
      clearWrites();
      pulseStart();
      applyStimulus(8'h08, 0);
      applyStimulus(8'h00, 0);
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) applyStimulus(prog[w].bytesLE[31-8*k -: 8], 0);
      end
      applyStimulus(8'hb3, 0);
      applyStimulus(8'h81, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset status {rdy,we,crst,busy,done,err}",
                  {26'd0, bus.in_ready, bus.mem_we, bus.core_reset, bus.busy, bus.done, bus.err},
                  32'b001000);
      checkOutput("midreset mem_addr", 32'(bus.mem_addr), 0);
      checkOutput("midreset mem_wdata", bus.mem_wdata, 0);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midreset writes kept", wrAddr.size(), 3);
      loadProgram(0, 1'b0, "fresh");

      // Half-rate stream, then start pulsed inside DATA.
      loadProgram(1, 1'b0, "toggle");
      loadProgram(0, 1'b1, "midStart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory loader for the RV32I core. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. It holds the core in reset until the whole program is written. It is the runtime replacement for preloading instruction memory from the testbench.

## Interface
- `ADDR_WIDTH`, default 8: instruction memory word-address width. Capacity is 2^ADDR_WIDTH words.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: one-cycle pulse that begins a load session. Honored only in IDLE, DONE or ERR.
- `in_valid`, input, 1: stream byte valid.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: loader can accept a byte.
- `mem_we`, output, 1: instruction memory write enable, one-cycle pulse.
- `mem_addr`, output, ADDR_WIDTH: word address of the write.
- `mem_wdata`, output, 32: instruction word to write.
- `core_reset`, output, 1: drives the RV32I core reset. High whenever the loader is not in DONE.
- `busy`, output, 1: load session in progress.
- `done`, output, 1: program loaded; core released.
- `err`, output, 1: word count exceeded capacity.

## Operation
- Stream format: 2-byte little-endian word count N, then 4·N bytes. Each word is least-significant byte first, so bytes 93 00 80 3e produce 0x3e800093.
- Byte transfer: a byte is accepted at a rising edge where `in_valid` and `in_ready` are both high. `in_valid` may drop at any time; gaps are allowed.
- FSM states:
  - IDLE → LEN_LO on `start`.
  - LEN_LO → LEN_HI on byte accept.
  - LEN_HI → DATA if 0 < N ≤ 2^ADDR_WIDTH.
  - LEN_HI → DONE if N = 0.
  - LEN_HI → ERR if N > 2^ADDR_WIDTH.
  - DATA → DONE after the write of word N−1.
  - DONE → LEN_LO on `start`.
  - ERR → LEN_LO on `start`.
- Counters:
  - 2-bit byte lane counter, cleared on entry to DATA.
  - ADDR_WIDTH+1-bit word counter, compared against N.
  - Write address equals the word index, starting at 0 for every session.
- Byte assembly: the lane k byte goes to shift register bits [8k+7:8k]. Acceptance of lane 3 schedules the write.
- Status outputs:
  - `in_ready` is high in LEN_LO, LEN_HI and DATA, and low otherwise.
  - `busy` is high in LEN_LO, LEN_HI and DATA.
  - `done` is high only in DONE.
  - `err` is high only in ERR.
  - `core_reset` stays high in ERR.
- `start` while `busy` is ignored.
- Reset mid-session: all state returns to reset values immediately. Partial words are discarded and no write is issued.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_reset`=1, `busy`=0, `done`=0, `err`=0. FSM resets to IDLE.
- Start latency: `start` sampled in cycle t gives `in_ready`=1 in cycle t+1.
- Write latency: lane-3 accept at edge t gives `mem_we`=1 with registered `mem_addr`/`mem_wdata` during cycle t+1, for exactly one cycle.
- No stall during writes: `in_ready` stays high during the write cycle. Back-to-back words at one byte per cycle are sustained.
- Release: the write of the final word occurs in cycle t+1. From edge t+2, the FSM is in DONE, `core_reset`=0, `done`=1 and `in_ready`=0.
- N = 0: the LEN_HI accept at edge t gives DONE from edge t+1, with no writes.
- Restart from DONE: `start` at edge t reasserts `core_reset` from edge t+1.
- Bytes offered while `in_ready`=0 are not consumed.

## Structure
- Package `imem_loader_pkg`:
  - FSM state enum (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR).
  - `LEN_BYTES`=2.
  - `WORD_BYTES`=4.
- Sub-module `byte_word_packer`:
  - Lane counter plus 32-bit shift/assemble register.
  - Emits a word-valid pulse with the assembled word.
  - Has a clear input driven on session start and on reset.
- Top level: FSM, word counter, length register, write-port registers.

## Test plan
- Load the 8-word multiply program: stream 08 00, then 93 00 80 3e, 13 01 30 00, … through 6f f3 5f ff.
  - Expect 8 `mem_we` pulses at addr 0..7.
  - Expect word 0 = 0x3e800093 and word 7 = 0xff5ff36f.
  - Expect `core_reset` to fall 2 cycles after the last byte accept.
- Same stream with `in_valid` toggling every other cycle: identical writes and data, with wider spacing between writes.
- Stream 00 00: no writes; `done`=1 and `core_reset`=0 one cycle after the second byte.
- With ADDR_WIDTH=8, stream 2c 01 (N=300): `err`=1, `in_ready`=0, `core_reset`=1, no writes. A later `start` with a valid stream succeeds.
- Assert `reset` after word 2 is written plus 2 bytes of word 3:
  - All outputs return to reset values asynchronously.
  - No write is issued for word 3.
  - A fresh session starts writing at addr 0.
- Pulse `start` during DATA: ignored, and the session completes normally. `start` in DONE: `core_reset` rises the next cycle.
